// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - opcodes, control-word bit map and fetch words
package control_sequencer_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'he;
  localparam logic [3:0] OP_HLT = 4'hf;

  // Strobe order HLT..FI, MSB first
  localparam int B_HLT = 15;
  localparam int B_MI  = 14;
  localparam int B_RI  = 13;
  localparam int B_RO  = 12;
  localparam int B_IO  = 11;
  localparam int B_II  = 10;
  localparam int B_AI  = 9;
  localparam int B_AO  = 8;
  localparam int B_EO  = 7;
  localparam int B_SU  = 6;
  localparam int B_BI  = 5;
  localparam int B_OI  = 4;
  localparam int B_CE  = 3;
  localparam int B_CO  = 2;
  localparam int B_J   = 1;
  localparam int B_FI  = 0;

  typedef logic [15:0] ctrl_word_t;

  typedef enum logic {
    SEQ_RUN  = 1'b0,
    SEQ_HALT = 1'b1
  } seq_state_t;

  function automatic ctrl_word_t cw(input int b);
    return ctrl_word_t'(1) << b;
  endfunction

  localparam ctrl_word_t CW_FETCH0 = (16'h1 << B_CO) | (16'h1 << B_MI);
  localparam ctrl_word_t CW_FETCH1 = (16'h1 << B_RO) | (16'h1 << B_II) | (16'h1 << B_CE);

endpackage

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational (step, opcode, flags) to control word
module microcode_rom
  import control_sequencer_pkg::*;
(
  input  logic [2:0] step,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output ctrl_word_t word
);

  always_comb begin
    word = '0;
    case (step)
      3'd0: word = CW_FETCH0;
      3'd1: word = CW_FETCH1;
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: word = cw(B_IO) | cw(B_MI);
          OP_LDI: word = cw(B_IO) | cw(B_AI);
          OP_JMP: word = cw(B_IO) | cw(B_J);
          OP_JC:  word = carry_flag ? (cw(B_IO) | cw(B_J)) : '0;
          OP_JZ:  word = zero_flag  ? (cw(B_IO) | cw(B_J)) : '0;
          OP_OUT: word = cw(B_AO) | cw(B_OI);
          OP_HLT: word = cw(B_HLT);
          default: word = '0;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA:         word = cw(B_RO) | cw(B_AI);
          OP_ADD, OP_SUB: word = cw(B_RO) | cw(B_BI);
          OP_STA:         word = cw(B_AO) | cw(B_RI);
          default:        word = '0;
        endcase
      end
      3'd4: begin
        case (opcode)
          OP_ADD:  word = cw(B_EO) | cw(B_AI) | cw(B_FI);
          OP_SUB:  word = cw(B_EO) | cw(B_AI) | cw(B_SU) | cw(B_FI);
          default: word = '0;
        endcase
      end
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T-state counter, halt latch and strobe fan-out
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int STEPS     = 5,
  parameter bit EARLY_END = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       HLT,
  output logic       MI,
  output logic       RI,
  output logic       RO,
  output logic       IO,
  output logic       II,
  output logic       AI,
  output logic       AO,
  output logic       EO,
  output logic       SU,
  output logic       BI,
  output logic       OI,
  output logic       CE,
  output logic       CO,
  output logic       J,
  output logic       FI,
  output logic [2:0] step,
  output logic       halted
);

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  seq_state_t state_q, state_d;
  logic [2:0] step_q, step_d, step_inc;
  ctrl_word_t cur_word, nxt_word, ctrl;

  assign step_inc = step_q + 3'd1;

  microcode_rom u_rom_cur (
    .step       (step_q),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .word       (cur_word)
  );

  // Lookahead at the following step drives the early return to T0
  microcode_rom u_rom_nxt (
    .step       (step_inc),
    .opcode     (opcode),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .word       (nxt_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEQ_RUN;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ctrl    = '0;
    case (state_q)
      SEQ_RUN: begin
        if (!rst) ctrl = cur_word;
        if (cur_word[B_HLT]) begin
          state_d = SEQ_HALT;
        end else if (step_q == LAST_STEP) begin
          step_d = 3'd0;
        end else if (EARLY_END && step_q >= 3'd2 && nxt_word == '0) begin
          step_d = 3'd0;
        end else begin
          step_d = step_inc;
        end
      end
      SEQ_HALT: begin
        state_d = SEQ_HALT;
      end
      default: begin
        state_d = SEQ_RUN;
      end
    endcase
  end

  assign step   = step_q;
  assign halted = (state_q == SEQ_HALT);

  assign HLT = ctrl[B_HLT];
  assign MI  = ctrl[B_MI];
  assign RI  = ctrl[B_RI];
  assign RO  = ctrl[B_RO];
  assign IO  = ctrl[B_IO];
  assign II  = ctrl[B_II];
  assign AI  = ctrl[B_AI];
  assign AO  = ctrl[B_AO];
  assign EO  = ctrl[B_EO];
  assign SU  = ctrl[B_SU];
  assign BI  = ctrl[B_BI];
  assign OI  = ctrl[B_OI];
  assign CE  = ctrl[B_CE];
  assign CO  = ctrl[B_CO];
  assign J   = ctrl[B_J];
  assign FI  = ctrl[B_FI];

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed vectors for control_sequencer
module tb_control_sequencer;

  // Control words, bit order HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI
  localparam logic [15:0] W_NONE  = 16'h0000;
  localparam logic [15:0] W_F0    = 16'h4004;
  localparam logic [15:0] W_F1    = 16'h1408;
  localparam logic [15:0] W_IO_AI = 16'h0A00;
  localparam logic [15:0] W_IO_MI = 16'h4800;
  localparam logic [15:0] W_RO_BI = 16'h1020;
  localparam logic [15:0] W_ADD4  = 16'h0281;
  localparam logic [15:0] W_SUB4  = 16'h02C1;
  localparam logic [15:0] W_IO_J  = 16'h0802;
  localparam logic [15:0] W_HLT   = 16'h8000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_b = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic carry_flag = 1'b0;
  logic zero_flag = 1'b0;

  logic a_hlt, a_mi, a_ri, a_ro, a_io, a_ii, a_ai, a_ao;
  logic a_eo, a_su, a_bi, a_oi, a_ce, a_co, a_j, a_fi;
  logic [2:0] a_step;
  logic a_halted;

  logic b_hlt, b_mi, b_ri, b_ro, b_io, b_ii, b_ai, b_ao;
  logic b_eo, b_su, b_bi, b_oi, b_ce, b_co, b_j, b_fi;
  logic [2:0] b_step;
  logic b_halted;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  control_sequencer #(.STEPS(5), .EARLY_END(1'b1)) dut_a (
    .clk(clk), .rst(rst), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .HLT(a_hlt), .MI(a_mi), .RI(a_ri), .RO(a_ro), .IO(a_io), .II(a_ii), .AI(a_ai), .AO(a_ao),
    .EO(a_eo), .SU(a_su), .BI(a_bi), .OI(a_oi), .CE(a_ce), .CO(a_co), .J(a_j), .FI(a_fi),
    .step(a_step), .halted(a_halted)
  );

  control_sequencer #(.STEPS(5), .EARLY_END(1'b0)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(4'h0), .carry_flag(1'b0), .zero_flag(1'b0),
    .HLT(b_hlt), .MI(b_mi), .RI(b_ri), .RO(b_ro), .IO(b_io), .II(b_ii), .AI(b_ai), .AO(b_ao),
    .EO(b_eo), .SU(b_su), .BI(b_bi), .OI(b_oi), .CE(b_ce), .CO(b_co), .J(b_j), .FI(b_fi),
    .step(b_step), .halted(b_halted)
  );

  wire [15:0] a_word = {a_hlt, a_mi, a_ri, a_ro, a_io, a_ii, a_ai, a_ao,
                        a_eo, a_su, a_bi, a_oi, a_ce, a_co, a_j, a_fi};
  wire [15:0] b_word = {b_hlt, b_mi, b_ri, b_ro, b_io, b_ii, b_ai, b_ao,
                        b_eo, b_su, b_bi, b_oi, b_ce, b_co, b_j, b_fi};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check dut_a step and word at the current point, then move to the next negedge
  task automatic step_a(input string tag, input logic [2:0] st, input logic [15:0] w);
    chk({tag, "_step"}, {13'd0, a_step}, {13'd0, st});
    chk({tag, "_word"}, a_word, w);
    @(negedge clk);
  endtask

  initial begin
    opcode = 4'h5;
    @(negedge clk);
    chk("rst_word", a_word, W_NONE);
    chk("rst_step", {13'd0, a_step}, 16'd0);
    chk("rst_halted", {15'd0, a_halted}, 16'd0);
    rst = 1'b0;
    #1;
    step_a("ldi_t0", 3'd0, W_F0);
    step_a("ldi_t1", 3'd1, W_F1);
    step_a("ldi_t2", 3'd2, W_IO_AI);

    opcode = 4'h2;
    step_a("add_t0", 3'd0, W_F0);
    step_a("add_t1", 3'd1, W_F1);
    step_a("add_t2", 3'd2, W_IO_MI);
    step_a("add_t3", 3'd3, W_RO_BI);
    step_a("add_t4", 3'd4, W_ADD4);

    opcode = 4'h3;
    step_a("sub_t0", 3'd0, W_F0);
    step_a("sub_t1", 3'd1, W_F1);
    step_a("sub_t2", 3'd2, W_IO_MI);
    step_a("sub_t3", 3'd3, W_RO_BI);
    step_a("sub_t4", 3'd4, W_SUB4);

    opcode = 4'h7;
    carry_flag = 1'b0;
    step_a("jc0_t0", 3'd0, W_F0);
    step_a("jc0_t1", 3'd1, W_F1);
    step_a("jc0_t2", 3'd2, W_NONE);
    carry_flag = 1'b1;
    step_a("jc1_t0", 3'd0, W_F0);
    step_a("jc1_t1", 3'd1, W_F1);
    step_a("jc1_t2", 3'd2, W_IO_J);

    opcode = 4'h8;
    carry_flag = 1'b0;
    zero_flag = 1'b0;
    step_a("jz0_t0", 3'd0, W_F0);
    step_a("jz0_t1", 3'd1, W_F1);
    step_a("jz0_t2", 3'd2, W_NONE);
    zero_flag = 1'b1;
    step_a("jz1_t0", 3'd0, W_F0);
    step_a("jz1_t1", 3'd1, W_F1);
    step_a("jz1_t2", 3'd2, W_IO_J);
    zero_flag = 1'b0;

    opcode = 4'hf;
    step_a("hlt_t0", 3'd0, W_F0);
    step_a("hlt_t1", 3'd1, W_F1);
    chk("hlt_pre_halted", {15'd0, a_halted}, 16'd0);
    step_a("hlt_t2", 3'd2, W_HLT);
    for (int i = 0; i < 10; i++) begin
      chk("halt_flag", {15'd0, a_halted}, 16'd1);
      step_a("halt_hold", 3'd2, W_NONE);
    end

    rst = 1'b1;
    #1;
    chk("hrst_step", {13'd0, a_step}, 16'd0);
    chk("hrst_halted", {15'd0, a_halted}, 16'd0);
    chk("hrst_word", a_word, W_NONE);
    rst = 1'b0;
    #1;
    chk("hrst_release_word", a_word, W_F0);
    opcode = 4'h2;
    @(negedge clk);
    step_a("add2_t1", 3'd1, W_F1);
    step_a("add2_t2", 3'd2, W_IO_MI);
    chk("add2_t3_word", a_word, W_RO_BI);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_word", a_word, W_NONE);
    chk("midrst_step", {13'd0, a_step}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    opcode = 4'h0;

    rst_b = 1'b1;
    #1;
    rst_b = 1'b0;
    #1;
    chk("b_t0_step", {13'd0, b_step}, 16'd0);
    chk("b_t0_word", b_word, W_F0);
    @(negedge clk);
    chk("b_t1_step", {13'd0, b_step}, 16'd1);
    chk("b_t1_word", b_word, W_F1);
    for (int s = 2; s <= 4; s++) begin
      @(negedge clk);
      chk("b_exec_step", {13'd0, b_step}, 16'(s));
      chk("b_exec_word", b_word, W_NONE);
    end
    @(negedge clk);
    chk("b_wrap_step", {13'd0, b_step}, 16'd0);
    chk("b_halted", {15'd0, b_halted}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode sequencer and decoder for the 8-bit computer. Drives the bus control strobes: CO, CE and J into the program counter, plus MI, RO, II, AI and the other register/ALU/output strobes.
- Holds a 3-bit T-state counter. Combines the T-state, the instruction register opcode and the flags register outputs to produce one control word per clock.
- Handles conditional jumps and HLT.

Parameters:
- STEPS, 5, T-states per instruction (T0..T4). Valid range 3..8.
- EARLY_END, 1: when 1, the counter returns to T0 after the last non-empty step of an instruction. When 0, the counter always runs to STEPS-1.

Ports:
- clk  input  1  system clock; all state changes on posedge
- rst  input  1  asynchronous, active-high reset
- opcode  input  4  upper nibble of the instruction register
- carry_flag  input  1  latched carry from the flags register
- zero_flag  input  1  latched zero from the flags register
- HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI  output  1 each  control strobes, active-high
- step  output  3  current T-state (debug/LEDs)
- halted  output  1  sequencer stopped by HLT

Behaviour:
- Reset (async, rst=1): step=0, halted=0. All 16 strobes forced 0 while rst is high. After rst deasserts, strobes resume decoding from T0 without waiting for a clock edge.
- Strobes are combinational from (step, opcode, flags, halted). Other modules sample them on the next posedge.
- Fetch is identical for every opcode:
  - T0: CO|MI
  - T1: RO|II|CE
- Execute steps (T2, T3, T4; unlisted steps are empty):
  - NOP 0000: none
  - LDA 0001: IO|MI ; RO|AI
  - ADD 0010: IO|MI ; RO|BI ; EO|AI|FI
  - SUB 0011: IO|MI ; RO|BI ; EO|AI|SU|FI
  - STA 0100: IO|MI ; AO|RI
  - LDI 0101: IO|AI
  - JMP 0110: IO|J
  - JC 0111: IO|J if carry_flag=1, else empty
  - JZ 1000: IO|J if zero_flag=1, else empty
  - OUT 1110: AO|OI
  - HLT 1111: HLT
  - 1001–1101: treated as NOP
- Flag conditions use the flag values present during the T2 cycle.
- Step advance at each posedge when not halted:
  - At step == STEPS-1, step becomes 0.
  - With EARLY_END=1, step becomes 0 when step ≥ 2 and the next step's word for the current opcode/flags is empty.
  - Otherwise step increments by 1.
  - A not-taken JC/JZ or a NOP therefore lasts 3 cycles.
- Halt: a posedge with HLT=1 sets halted=1 and freezes step. While halted, all strobes are 0, including HLT. Only rst clears halted.
- opcode may change at the T1 edge (II loads IR). Decode must use the live opcode; no internal copy of the opcode.
- Reset mid-instruction: the instruction is abandoned immediately; no partial strobes appear after rst rises.

Decomposition:
- Shared header control_defs.v holds:
  - opcode constants (OP_NOP … OP_HLT)
  - control-word bit positions for the 16 strobes, in the order HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI, MSB first
  - the fetch words as constants
- Sub-module microcode_rom: purely combinational, mapping (step, opcode, carry_flag, zero_flag) to a 16-bit control word. control_sequencer owns the counter, halt latch, early-end logic and the fan-out to named ports.

Test Plan:
- Reset then 2 clocks with opcode=0101 → T0 CO=MI=1; T1 RO=II=CE=1; T2 IO=AI=1; next edge step=0 (EARLY_END=1).
- opcode=0010 for 5 clocks → step sequence 0,1,2,3,4,0. T4 word = EO|AI|FI with SU=0; opcode=0011 gives the same plus SU=1.
- opcode=0111, carry_flag=0 → T2 all strobes 0, step 2→0. With carry_flag=1 → T2 IO=J=1. JZ checked the same way with zero_flag.
- opcode=1111 → T2 HLT=1; after that edge halted=1, step frozen at 2, all strobes 0 for 10 clocks. Pulse rst → step=0, halted=0, CO=MI=1.
- rst asserted mid-cycle at step=3 of ADD, between clock edges → strobes go 0 and step=0 before the next posedge.
- EARLY_END=0, opcode=0000 → step runs 0..4 with T2–T4 words all zero.
